// File: rtl/ubi_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : ubi_stream_pkg                                                 |
// | Shared types and width helpers for the unary-stream-to-binary converter. |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package ubi_stream_pkg;

    // Window FSM states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int INWD_DEFAULT = 8;

    // Window length N = 2^inwd enabled cycles
    function automatic int win_len(input int inwd);
        return 1 << inwd;
    endfunction

    // Width able to hold 0..N (ones-count and window counter)
    function automatic int cnt_w(input int inwd);
        return inwd + 1;
    endfunction

    // Width able to hold -N..+N in two's complement
    function automatic int bi_w(input int inwd);
        return inwd + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ubi_win_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ubi_win_cnt                                                    |
// | Enable-gated window counter. A clear may coincide with an enabled sample |
// | so that sample becomes the first of the new window (count restarts at 1).|
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ubi_win_cnt
    import ubi_stream_pkg::*;
#(
    parameter int INWD = INWD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int CW = cnt_w(INWD);
    localparam logic [CW-1:0] LAST = CW'(win_len(INWD) - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Next count: clear wins over increment, but still counts a coincident sample
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {{(CW-1){1'b0}}, en};
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Terminal: the sample being counted on this edge is the Nth of the window
    assign term = en & ~clr & (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/ubi_stream_to_bin.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ubi_stream_to_bin                                              |
// | Counts ones of a bipolar unary stream over N = 2^INWD enabled cycles and |
// | reports the ones-count and the bipolar value 2*ones - N.                 |
// | Option  : UBI_STREAM_TO_BIN_CONT_EN - back-to-back windows after start.  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ubi_stream_to_bin
    import ubi_stream_pkg::*;
#(
    parameter int INWD = INWD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   iStream,
    input  logic                   iEn,
    input  logic                   start,
    output logic                   oBusy,
    output logic                   oValid,
    output logic [INWD:0]          oCnt,
    output logic signed [INWD+1:0] oBi
);

    localparam int CW = cnt_w(INWD);
    localparam int BW = bi_w(INWD);
    localparam logic [BW-1:0] N_BI   = BW'(win_len(INWD));
    localparam logic [BW-1:0] BI_RST = BW'(0) - N_BI;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] acc_q;
    logic [CW-1:0] acc_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [BW-1:0] bi_q;
    logic [BW-1:0] bi_d;
    logic [CW-1:0] acc_sum;
    logic          wc_clr;
    logic          wc_en;
    logic          wc_term;

    // Accumulator plus the bit arriving on this edge (never wraps: max is N)
    assign acc_sum = acc_q + {{(CW-1){1'b0}}, iStream};

    ubi_win_cnt #(
        .INWD (INWD)
    ) u_win_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wc_clr),
        .en    (wc_en),
        .term  (wc_term)
    );

    // State, accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            bi_q    <= BI_RST;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bi_q    <= bi_d;
        end
    end

    // Next-state logic; start outside IDLE is simply not looked at
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)   state_d = ST_RUN;
            ST_RUN:  if (wc_term) state_d = ST_DONE;
`ifdef UBI_STREAM_TO_BIN_CONT_EN
            ST_DONE: state_d = ST_RUN;
`else
            ST_DONE: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath control: window clear, accumulate, capture result on terminal edge
    always_comb begin
        wc_clr = 1'b0;
        wc_en  = 1'b0;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        bi_d   = bi_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wc_clr = 1'b1;
                    acc_d  = '0;
                end
            end
            ST_RUN: begin
                wc_en = iEn;
                if (iEn) begin
                    acc_d = acc_sum;
                end
                if (wc_term) begin
                    cnt_d = acc_sum;
                    bi_d  = {acc_sum, 1'b0} - N_BI;
                end
            end
            ST_DONE: begin
`ifdef UBI_STREAM_TO_BIN_CONT_EN
                // Restart in place; this edge's bit opens the next window
                wc_clr = 1'b1;
                wc_en  = iEn;
                acc_d  = iEn ? {{(CW-1){1'b0}}, iStream} : '0;
`endif
            end
            default: begin
                acc_d = '0;
            end
        endcase
    end

    // Output decode from registered state and results
    always_comb begin
        oBusy  = (state_q != ST_IDLE);
        oValid = (state_q == ST_DONE);
        oCnt   = cnt_q;
        oBi    = bi_q;
    end

endmodule
`default_nettype wire
